axis_keep_packer: RTL and testbench
===================================

Name: axis_keep_packer

Overview:
Parametrised successor to the single-word AXI-Stream-to-FIFO writer. Accepts AXI-Stream beats with sparse byte enables (tkeep), compacts the kept bytes, and repacks them into dense words for the downstream write FIFO. Carries packet boundaries (tlast) through as a word_last flag, with a partial-word keep mask on the final word. Sits between the DSP stream source and the write-side FIFO; backpressure comes from the FIFO's full flag.

Parameters:
T_DATA_W, 4, stream width in bytes (N ≥ 1); data width is 8*N
CNT_W, 16, width of the completed-packet counter

Ports:
aclk  in  1  clock; all logic on the rising edge
areset  in  1  asynchronous, active-high reset
s_tdata  in  8*N  input beat data; byte lane i = bits [8i+7:8i]
s_tkeep  in  N  per-lane keep; 1 = byte valid
s_tlast  in  1  last beat of packet
s_tvalid  in  1  beat valid
s_tready  out  1  beat accepted when s_tvalid & s_tready
full  in  1  downstream FIFO almost-full (asserted when ≤1 free entry)
data_word  out  8*N  packed word to FIFO
word_keep  out  N  valid lanes of data_word (contiguous from lane 0)
word_last  out  1  word closes a packet
w_en  out  1  FIFO write strobe, one cycle per word
pkt_cnt  out  CNT_W  completed packets, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, areset=1): all outputs 0, fill count F=0, residual buffer 0, state PACK.
- The compactor orders kept bytes by ascending lane index; K = popcount(s_tkeep).
- State PACK: s_tready = ~full. On acceptance, the K bytes are appended at positions F..F+K-1 of a 2N-byte buffer.
  - If F+K ≥ N: emit the low N bytes with keep all ones. word_last = s_tlast & (F+K==N). Shift the residual down; F ← F+K-N. If s_tlast and the new F > 0, go to FLUSH.
  - If F+K < N and s_tlast: emit a partial word with keep = (1<<(F+K))-1, word_last=1, F ← 0. This includes F+K=0, which emits keep=0 with word_last=1 to preserve the boundary.
  - If F+K < N and ~s_tlast: no write; F ← F+K. A beat with K=0 and no tlast is accepted silently.
- State FLUSH: s_tready=0. When ~full, emit the residual with keep = (1<<F)-1 and word_last=1; F ← 0; go to PACK. While full, hold FLUSH.
- Outputs are registered, with 1-cycle latency from the accepting edge to w_en. w_en pulses for exactly one cycle. data_word/word_keep/word_last hold their last values when w_en=0.
- Unused lanes of a partial word are driven 0.
- pkt_cnt increments on each write with word_last=1.
- Backpressure: no write is issued while full=1. Because of the registered-output latency, full must be an almost-full flag with one entry of slack.
- areset mid-packet: the partial packet is discarded and the next beat starts at lane 0.

Decomposition:
- Package axis_pkg: byte constant 8, state enum {PACK, FLUSH}, keep-mask function (1<<n)-1.
- Sub-module axis_keep_compactor: combinational; inputs tdata/tkeep; outputs compacted bytes and popcount K.

Test Plan:
- N=4, tdata=0xAABBCCDD, tkeep=4'b1111, tlast=1 -> next cycle: w_en=1, data_word=0xAABBCCDD, keep=4'hF, last=1; pkt_cnt=1.
- Beat tdata=0x11223344 keep=0011, then tdata=0x55667788 keep=0011 tlast=1 -> one write: 0x77883344, keep=F, last=1; no write after the first beat.
- Beats 0x00CCBBAA, 0x00FFEEDD, 0x00332211 (last), all keep=0111 -> writes 0xDDCCBBAA (F, last 0), then 0x2211FFEE (F, last 0), then 0x00000033 (keep 0001, last 1); s_tready=0 during the FLUSH cycle.
- full=1 for 3 cycles with a valid beat pending -> s_tready=0 and no w_en; the beat is accepted on the first cycle after full drops.
- keep=0000 tlast=1 with F=0 -> write with keep=0, last=1, pkt_cnt+1. Then keep=0000 tlast=0 -> accepted, no write.
- areset pulsed with F=2 mid-packet -> all outputs 0, pkt_cnt=0. Next beat 0xAABBCCDD keep=F last=1 -> 0xAABBCCDD unshifted.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared constants, state encoding and keep-mask helper for the AXI-Stream keep packer.
package axis_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    PACK  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Contiguous low-lane mask with n ones; callers size-cast to their lane count.
  function automatic logic [63:0] keep_mask(input int n);
    keep_mask = (64'd1 << n) - 64'd1;
  endfunction

endpackage

// File: rtl/axis_keep_compactor.sv
// Combinational byte compactor: moves kept lanes down to lane 0 in ascending order and counts them.
module axis_keep_compactor
  import axis_pkg::*;
#(
  parameter int N  = 4,
  parameter int KW = $clog2(N + 1)
) (
  input  logic [N*BYTE_W-1:0] tdata,
  input  logic [N-1:0]        tkeep,
  output logic [N*BYTE_W-1:0] cbytes,
  output logic [KW-1:0]       k_cnt
);

  int idx;

  // Lanes above the kept count stay zero so they can be OR-merged into the residual.
  always_comb begin
    cbytes = '0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      if (tkeep[i]) begin
        cbytes[idx*BYTE_W +: BYTE_W] = tdata[i*BYTE_W +: BYTE_W];
        idx = idx + 1;
      end
    end
    k_cnt = KW'(idx);
  end

endmodule

// File: rtl/axis_keep_packer.sv
// Repacks sparse-keep AXI-Stream beats into dense FIFO words, carrying tlast as word_last.
// Handshake: a beat transfers on a rising edge where s_tvalid & s_tready; w_en is a one-cycle write strobe.
module axis_keep_packer
  import axis_pkg::*;
#(
  parameter int T_DATA_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [T_DATA_W*BYTE_W-1:0] s_tdata,
  input  logic [T_DATA_W-1:0]        s_tkeep,
  input  logic                       s_tlast,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic                       full,
  output logic [T_DATA_W*BYTE_W-1:0] data_word,
  output logic [T_DATA_W-1:0]        word_keep,
  output logic                       word_last,
  output logic                       w_en,
  output logic [CNT_W-1:0]           pkt_cnt,
  output state_e                     dbg_state
);

  localparam int N  = T_DATA_W;
  localparam int DW = N * BYTE_W;
  localparam int KW = $clog2(N + 1);
  localparam int CW = $clog2(2 * N + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     fill_q, fill_d;
  logic [DW-1:0]     res_q, res_d;
  logic [DW-1:0]     data_word_q, data_word_d;
  logic [N-1:0]      word_keep_q, word_keep_d;
  logic              word_last_q, word_last_d;
  logic              w_en_q, w_en_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

  logic [DW-1:0]     cbytes;
  logic [KW-1:0]     k_cnt;
  logic [CW-1:0]     sum;
  logic [2*DW-1:0]   merged;
  logic              accept;

  axis_keep_compactor #(.N(N), .KW(KW)) u_compactor (
    .tdata  (s_tdata),
    .tkeep  (s_tkeep),
    .cbytes (cbytes),
    .k_cnt  (k_cnt)
  );

  assign s_tready = (state_q == PACK) & ~full & ~areset;
  assign accept   = s_tvalid & s_tready;
  assign sum      = fill_q + CW'(k_cnt);
  // Residual bytes above fill_q are always zero, so appending is a shifted OR.
  assign merged   = {{DW{1'b0}}, res_q} | ({{DW{1'b0}}, cbytes} << {fill_q, 3'b000});

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    res_d       = res_q;
    data_word_d = data_word_q;
    word_keep_d = word_keep_q;
    word_last_d = word_last_q;
    w_en_d      = 1'b0;
    case (state_q)
      PACK: begin
        if (accept) begin
          if (sum >= CW'(N)) begin
            data_word_d = merged[DW-1:0];
            word_keep_d = '1;
            word_last_d = s_tlast & (sum == CW'(N));
            w_en_d      = 1'b1;
            res_d       = merged[2*DW-1:DW];
            fill_d      = sum - CW'(N);
            if (s_tlast && (sum != CW'(N))) state_d = FLUSH;
          end else if (s_tlast) begin
            data_word_d = merged[DW-1:0];
            word_keep_d = N'(keep_mask(int'(sum)));
            word_last_d = 1'b1;
            w_en_d      = 1'b1;
            res_d       = '0;
            fill_d      = '0;
          end else begin
            res_d  = merged[DW-1:0];
            fill_d = sum;
          end
        end
      end
      FLUSH: begin
        if (!full) begin
          data_word_d = res_q;
          word_keep_d = N'(keep_mask(int'(fill_q)));
          word_last_d = 1'b1;
          w_en_d      = 1'b1;
          res_d       = '0;
          fill_d      = '0;
          state_d     = PACK;
        end
      end
      default: state_d = PACK;
    endcase
    pkt_cnt_d = pkt_cnt_q;
    if (w_en_d && word_last_d) pkt_cnt_d = pkt_cnt_q + 1'b1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= PACK;
      fill_q      <= '0;
      res_q       <= '0;
      data_word_q <= '0;
      word_keep_q <= '0;
      word_last_q <= 1'b0;
      w_en_q      <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      res_q       <= res_d;
      data_word_q <= data_word_d;
      word_keep_q <= word_keep_d;
      word_last_q <= word_last_d;
      w_en_q      <= w_en_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign data_word = data_word_q;
  assign word_keep = word_keep_q;
  assign word_last = word_last_q;
  assign w_en      = w_en_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_axis_keep_packer.sv
// Directed bench for axis_keep_packer (N=4): scoreboard of expected FIFO writes plus counter/state checks.
module tb_axis_keep_packer;
  import axis_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int W  = DW + N + 1;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic [N-1:0]  s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          full = 1'b0;
  logic [DW-1:0] data_word;
  logic [N-1:0]  word_keep;
  logic          word_last;
  logic          w_en;
  logic [15:0]   pkt_cnt;
  state_e        dbg_state;

  int tests = 0;
  int failed = 0;
  int wr_cnt = 0;
  int wr0;
  logic [W-1:0] exp_q[$];

  axis_keep_packer #(.T_DATA_W(N), .CNT_W(16)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .s_tdata   (s_tdata),
    .s_tkeep   (s_tkeep),
    .s_tlast   (s_tlast),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .full      (full),
    .data_word (data_word),
    .word_keep (word_keep),
    .word_last (word_last),
    .w_en      (w_en),
    .pkt_cnt   (pkt_cnt),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write is matched against the next expected word
  always @(negedge aclk) begin
    if (w_en) begin
      wr_cnt++;
      check_eq("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check_eq("write_word", 64'({data_word, word_keep, word_last}), 64'(exp_q.pop_front()));
    end
  end

  task automatic expect_word(input logic [DW-1:0] d, input logic [N-1:0] k, input logic l);
    exp_q.push_back({d, k, l});
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [N-1:0] k, input logic l);
    logic acc;
    acc = 1'b0;
    @(negedge aclk);
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (s_tready) begin
        acc = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    check_eq("accept_timeout", 64'(acc), 64'd1);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
  endtask

  initial begin
    repeat (3) @(negedge aclk);
    check_eq("rst_w_en", 64'(w_en), 64'd0);
    check_eq("rst_data", 64'(data_word), 64'd0);
    check_eq("rst_keep", 64'(word_keep), 64'd0);
    check_eq("rst_last", 64'(word_last), 64'd0);
    check_eq("rst_pkt", 64'(pkt_cnt), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'(PACK));
    areset = 1'b0;
    idle(2);

    // full single beat
    expect_word(32'hAABBCCDD, 4'hF, 1'b1);
    send(32'hAABBCCDD, 4'b1111, 1'b1);
    check_eq("t1_latency", 64'(w_en), 64'd1);
    idle(2);
    check_eq("t1_pkt", 64'(pkt_cnt), 64'd1);
    check_eq("t1_wr", 64'(wr_cnt), 64'd1);

    // two half beats merge into one word
    send(32'h11223344, 4'b0011, 1'b0);
    idle(2);
    check_eq("t2_no_write", 64'(wr_cnt), 64'd1);
    expect_word(32'h77883344, 4'hF, 1'b1);
    send(32'h55667788, 4'b0011, 1'b1);
    idle(2);
    check_eq("t2_pkt", 64'(pkt_cnt), 64'd2);

    // three-byte beats spill into a flush word
    expect_word(32'hDDCCBBAA, 4'hF, 1'b0);
    expect_word(32'h2211FFEE, 4'hF, 1'b0);
    expect_word(32'h00000033, 4'h1, 1'b1);
    send(32'h00CCBBAA, 4'b0111, 1'b0);
    send(32'h00FFEEDD, 4'b0111, 1'b0);
    send(32'h00332211, 4'b0111, 1'b1);
    check_eq("t3_flush_state", 64'(dbg_state), 64'(FLUSH));
    check_eq("t3_flush_ready", 64'(s_tready), 64'd0);
    idle(3);
    check_eq("t3_pkt", 64'(pkt_cnt), 64'd3);
    check_eq("t3_wr", 64'(wr_cnt), 64'd5);

    // backpressure with a pending beat
    wr0 = wr_cnt;
    @(negedge aclk);
    full = 1'b1;
    s_tdata = 32'h01020304; s_tkeep = 4'hF; s_tlast = 1'b1; s_tvalid = 1'b1;
    expect_word(32'h01020304, 4'hF, 1'b1);
    repeat (3) begin
      #1 check_eq("t4_ready_low", 64'(s_tready), 64'd0);
      @(negedge aclk);
    end
    check_eq("t4_no_write", 64'(wr_cnt), 64'(wr0));
    full = 1'b0;
    #1 check_eq("t4_ready_high", 64'(s_tready), 64'd1);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    check_eq("t4_w_en", 64'(w_en), 64'd1);
    idle(2);
    check_eq("t4_pkt", 64'(pkt_cnt), 64'd4);

    // flush held while full
    expect_word(32'h04030201, 4'hF, 1'b0);
    expect_word(32'h00000605, 4'h3, 1'b1);
    wr0 = wr_cnt;
    send(32'h00030201, 4'b0111, 1'b0);
    send(32'h00060504, 4'b0111, 1'b1);
    full = 1'b1;
    idle(3);
    check_eq("t5_flush_hold_wr", 64'(wr_cnt), 64'(wr0 + 1));
    check_eq("t5_flush_hold_state", 64'(dbg_state), 64'(FLUSH));
    full = 1'b0;
    idle(2);
    check_eq("t5_pkt", 64'(pkt_cnt), 64'd5);
    check_eq("t5_state", 64'(dbg_state), 64'(PACK));

    // empty beats
    expect_word(32'h00000000, 4'h0, 1'b1);
    send(32'hDEADBEEF, 4'b0000, 1'b1);
    idle(2);
    check_eq("t6_pkt", 64'(pkt_cnt), 64'd6);
    wr0 = wr_cnt;
    send(32'hDEADBEEF, 4'b0000, 1'b0);
    idle(2);
    check_eq("t6_silent", 64'(wr_cnt), 64'(wr0));

    // reset mid-packet discards residual
    send(32'h11223344, 4'b0011, 1'b0);
    idle(1);
    areset = 1'b1;
    #1;
    check_eq("t7_rst_pkt", 64'(pkt_cnt), 64'd0);
    check_eq("t7_rst_last", 64'(word_last), 64'd0);
    check_eq("t7_rst_w_en", 64'(w_en), 64'd0);
    check_eq("t7_rst_data", 64'(data_word), 64'd0);
    idle(2);
    areset = 1'b0;
    expect_word(32'hAABBCCDD, 4'hF, 1'b1);
    send(32'hAABBCCDD, 4'b1111, 1'b1);
    idle(2);
    check_eq("t7_pkt", 64'(pkt_cnt), 64'd1);

    check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
